psk_symbol_mapper: RTL

Downstream neighbour of the packetizer in the TX chain. Consumes its AXIS symbol stream: one BPSK bit or one QPSK dibit per beat, with `tuser` carrying is_bpsk. Each symbol is optionally differentially encoded, mapped to a signed 16-bit I/Q constellation point, and repeated SPS times to form the sample stream for the pulse-shaping filter. Full AXIS backpressure is supported on both sides, and packet boundaries (`tlast`) are preserved.

---
 rtl/psk_symbol_mapper.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/psk_symbol_mapper.sv
// PSK symbol mapper: maps BPSK bits / QPSK dibits to I/Q constellation points
// (optionally differential) and repeats each point SPS times on an AXIS output.
module psk_symbol_mapper #(
    parameter int unsigned BYTES = 1,
    parameter int unsigned SPS   = 8,
    parameter int          AMP   = 23170,
    parameter bit          DIFF  = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clk_enable,
    input  logic [BYTES*8-1:0] I_tdata,
    input  logic               I_tvalid,
    output logic               I_tready,
    input  logic               I_tlast,
    input  logic               I_tuser,
    output logic [31:0]        O_tdata,
    output logic               O_tvalid,
    input  logic               O_tready,
    output logic               O_tlast,
    output logic               O_tuser,
    output logic [15:0]        sym_cnt,
    output logic               busy
);

    typedef enum logic [0:0] {
        StIdle,
        StHold
    } state_t;

    localparam logic [7:0]         LAST_SAMP = 8'(SPS - 1);
    localparam logic signed [15:0] AMP_P     = 16'(AMP);
    localparam logic signed [15:0] AMP_N     = -AMP_P;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [7:0]   r_samp_cnt;
    logic [7:0]   w_samp_nxt;
    logic [31:0]  r_data;
    logic [31:0]  w_data_nxt;
    logic         r_user;
    logic         w_user_nxt;
    logic         r_last;
    logic         w_last_nxt;
    logic [1:0]   r_acc;
    logic [1:0]   w_acc_nxt;
    logic [15:0]  r_sym_cnt;
    logic [15:0]  w_sym_nxt;

    logic         w_last_samp;
    logic         w_beat;
    logic         w_itrans;
    logic         w_pkt_end;
    logic [1:0]   w_acc_base;
    logic [15:0]  w_sym_base;
    logic [1:0]   w_delta;
    logic [1:0]   w_phase;
    logic [15:0]  w_i;
    logic [15:0]  w_q;
    logic         w_unused_bits;

    assign w_unused_bits = ^I_tdata[BYTES*8-1:2];

    assign w_last_samp = (r_samp_cnt == LAST_SAMP);
    assign O_tvalid    = (r_state == StHold);
    assign busy        = (r_state == StHold);
    assign w_beat      = O_tvalid && O_tready && clk_enable;
    assign I_tready    = clk_enable && ((r_state == StIdle) || (O_tready && w_last_samp));
    assign w_itrans    = I_tvalid && I_tready;
    assign w_pkt_end   = w_beat && w_last_samp && r_last;

    // A symbol accepted on the packet-closing beat starts from a cleared phase/count.
    assign w_acc_base  = w_pkt_end ? 2'd0 : r_acc;
    assign w_sym_base  = w_pkt_end ? 16'd0 : r_sym_cnt;

    // BPSK: 0/1 -> 0/2. QPSK Gray: 00->0, 01->1, 11->2, 10->3.
    always_comb begin
        w_delta = 2'd0;
        if (I_tuser) begin
            w_delta = {I_tdata[0], 1'b0};
        end else begin
            w_delta = {I_tdata[1], I_tdata[1] ^ I_tdata[0]};
        end
    end

    assign w_phase = DIFF ? (w_acc_base + w_delta) : w_delta;

    always_comb begin
        w_i = 16'd0;
        w_q = 16'd0;
        unique case (w_phase)
            2'd0: w_i = AMP_P;
            2'd1: w_q = AMP_P;
            2'd2: w_i = AMP_N;
            2'd3: w_q = AMP_N;
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_samp_nxt  = r_samp_cnt;
        w_data_nxt  = r_data;
        w_user_nxt  = r_user;
        w_last_nxt  = r_last;
        w_acc_nxt   = w_acc_base;
        w_sym_nxt   = w_sym_base;

        if (w_beat) begin
            if (w_last_samp) begin
                w_state_nxt = StIdle;
                w_samp_nxt  = 8'd0;
                w_last_nxt  = 1'b0;
            end else begin
                w_samp_nxt  = r_samp_cnt + 8'd1;
            end
        end

        // A load overrides the end-of-symbol return to idle (back-to-back streaming).
        if (w_itrans) begin
            w_state_nxt = StHold;
            w_samp_nxt  = 8'd0;
            w_data_nxt  = {w_q, w_i};
            w_user_nxt  = I_tuser;
            w_last_nxt  = I_tlast;
            if (DIFF) begin
                w_acc_nxt = w_phase;
            end
            if (w_sym_base != 16'hFFFF) begin
                w_sym_nxt = w_sym_base + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_samp_cnt <= 8'd0;
            r_data     <= 32'd0;
            r_user     <= 1'b1;
            r_last     <= 1'b0;
            r_acc      <= 2'd0;
            r_sym_cnt  <= 16'd0;
        end else if (clk_enable) begin
            r_state    <= w_state_nxt;
            r_samp_cnt <= w_samp_nxt;
            r_data     <= w_data_nxt;
            r_user     <= w_user_nxt;
            r_last     <= w_last_nxt;
            r_acc      <= w_acc_nxt;
            r_sym_cnt  <= w_sym_nxt;
        end
    end

    assign O_tdata = r_data;
    assign O_tuser = r_user;
    assign O_tlast = r_last && w_last_samp;
    assign sym_cnt = r_sym_cnt;

endmodule
